rose_delay_checker: RTL and testbench

//  Synthesisable multi-channel temporal checker, per channel i:
//    $rose(a_i) |-> $rose(b_i) at an edge MIN_DLY..MAX_DLY clocks later.

---
 rtl/rose_delay_checker.sv | 158 +++++++++++++++
 tb/tb_rose_delay_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rose_delay_checker.sv
// Multi-channel "$rose(a) |-> ##[MIN_DLY:MAX_DLY] $rose(b)" hardware checker with pass/fail pulses,
// saturating counters and a sticky first-fail report. Define RDC_SVA_EN to add simulation-only SVA cross-checks.
module rose_delay_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 2,
  parameter int CNT_W   = 16,
  localparam int FCW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [NUM_CH-1:0]         a_i,
  input  logic [NUM_CH-1:0]         b_i,
  output logic [NUM_CH-1:0]         pass_o,
  output logic [NUM_CH-1:0]         fail_o,
  output logic [NUM_CH*CNT_W-1:0]   pass_cnt_o,
  output logic [NUM_CH*CNT_W-1:0]   fail_cnt_o,
  output logic                      err_o,
  output logic [FCW-1:0]            first_fail_ch_o
);

  function automatic logic [MAX_DLY-1:0] win_mask();
    logic [MAX_DLY-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_DLY; j++) m[j] = ((j + 1) >= MIN_DLY);
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [FCW-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    logic [FCW-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) idx = FCW'(i);
    return idx;
  endfunction

  localparam logic [MAX_DLY-1:0] WIN = win_mask();

  logic [NUM_CH-1:0]  r_a_q, r_b_q;
  // Bit k-1 of r_age[i]: an attempt on channel i that will be age k at the next edge.
  logic [MAX_DLY-1:0] r_age [NUM_CH];
  logic [NUM_CH-1:0]  r_pass, r_fail;
  logic [CNT_W-1:0]   r_pass_cnt [NUM_CH];
  logic [CNT_W-1:0]   r_fail_cnt [NUM_CH];
  logic               r_err;
  logic [FCW-1:0]     r_ffc;

  logic [NUM_CH-1:0]  w_rose_a, w_rose_b, w_launch, w_pass, w_fail;
  logic [MAX_DLY-1:0] w_hit      [NUM_CH];
  logic [MAX_DLY-1:0] w_surv     [NUM_CH];
  logic [MAX_DLY-1:0] w_age_nxt  [NUM_CH];

  assign w_rose_a = a_i & ~r_a_q;
  assign w_rose_b = b_i & ~r_b_q;
  assign w_launch = w_rose_a & {NUM_CH{en_i}};

  // Pass discharges every in-window attempt; whatever survives at the oldest slot has expired.
  // The new launch enters after resolution, so a same-edge b-rise never touches it.
  always_comb begin
    w_pass = '0;
    w_fail = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i]     = r_age[i] & WIN & {MAX_DLY{w_rose_b[i]}};
      w_surv[i]    = r_age[i] & ~w_hit[i];
      w_pass[i]    = |w_hit[i];
      w_fail[i]    = w_surv[i][MAX_DLY-1];
      w_age_nxt[i] = (w_surv[i] << 1) | MAX_DLY'(w_launch[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q  <= '0;
      r_b_q  <= '0;
      r_pass <= '0;
      r_fail <= '0;
      for (int i = 0; i < NUM_CH; i++) r_age[i] <= '0;
    end else begin
      r_a_q  <= a_i;
      r_b_q  <= b_i;
      r_pass <= w_pass;
      r_fail <= w_fail;
      for (int i = 0; i < NUM_CH; i++) r_age[i] <= w_age_nxt[i];
    end
  end

  // Counters and the sticky error follow the pulse registers; a result in the clear cycle survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_ffc <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pass_cnt[i] <= '0;
        r_fail_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_i) begin
          r_pass_cnt[i] <= CNT_W'(w_pass[i]);
          r_fail_cnt[i] <= CNT_W'(w_fail[i]);
        end else begin
          if (w_pass[i]) r_pass_cnt[i] <= sat_inc(r_pass_cnt[i]);
          if (w_fail[i]) r_fail_cnt[i] <= sat_inc(r_fail_cnt[i]);
        end
      end
      if (clr_i) begin
        r_err <= |w_fail;
        r_ffc <= (|w_fail) ? lowest_idx(w_fail) : '0;
      end else if (!r_err && (|w_fail)) begin
        r_err <= 1'b1;
        r_ffc <= lowest_idx(w_fail);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign pass_cnt_o[g*CNT_W +: CNT_W] = r_pass_cnt[g];
    assign fail_cnt_o[g*CNT_W +: CNT_W] = r_fail_cnt[g];
  end

  assign pass_o          = r_pass;
  assign fail_o          = r_fail;
  assign err_o           = r_err;
  assign first_fail_ch_o = r_ffc;

`ifdef RDC_SVA_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sva
    int unsigned n_sva_fail = 0;
    int unsigned n_hw_fail  = 0;

    a_rose_dly : assert property (@(posedge clk) disable iff (!rst_n)
      en_i && $rose(a_i[g]) |-> ##[MIN_DLY:MAX_DLY] $rose(b_i[g]))
      $info("rose_delay_checker ch%0d attempt satisfied", g);
    else begin
      n_sva_fail++;
      $error("rose_delay_checker ch%0d attempt expired", g);
    end

    // Both tallies have settled by the falling edge; every SVA failure must match one fail_o pulse.
    always @(negedge clk) begin
      if (!rst_n) begin
        n_sva_fail = 0;
        n_hw_fail  = 0;
      end else begin
        if (fail_o[g]) n_hw_fail++;
        a_fail_match : assert (n_hw_fail == n_sva_fail)
          else $error("rose_delay_checker ch%0d fail_o disagrees with SVA", g);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rose_delay_checker.sv
// Bench for rose_delay_checker: two instances (exact delay, windowed), table vectors,
// directed corner sequences and randomized stimulus against a launch-timestamp queue model.
module tb_rose_delay_checker;
  localparam int NCH = 4;
  localparam int MIN_A = 2, MAX_A = 2, CW_A = 4;
  localparam int MIN_B = 2, MAX_B = 4, CW_B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_in = 1'b1, clr_in = 1'b0;
  logic [NCH-1:0] a_in = '0, b_in = '0;

  logic [NCH-1:0] pass_a, fail_a, pass_b, fail_b;
  logic [NCH*CW_A-1:0] pcnt_a, fcnt_a;
  logic [NCH*CW_B-1:0] pcnt_b, fcnt_b;
  logic err_a, err_b;
  logic [1:0] ffc_a, ffc_b;

  always #5 clk = ~clk;

  rose_delay_checker #(.NUM_CH(NCH), .MIN_DLY(MIN_A), .MAX_DLY(MAX_A), .CNT_W(CW_A)) u_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_in), .clr_i(clr_in), .a_i(a_in), .b_i(b_in),
    .pass_o(pass_a), .fail_o(fail_a), .pass_cnt_o(pcnt_a), .fail_cnt_o(fcnt_a),
    .err_o(err_a), .first_fail_ch_o(ffc_a));

  rose_delay_checker #(.NUM_CH(NCH), .MIN_DLY(MIN_B), .MAX_DLY(MAX_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_in), .clr_i(clr_in), .a_i(a_in), .b_i(b_in),
    .pass_o(pass_b), .fail_o(fail_b), .pass_cnt_o(pcnt_b), .fail_cnt_o(fcnt_b),
    .err_o(err_b), .first_fail_ch_o(ffc_b));

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: each pending attempt is just its launch edge number.
  int lq [2][NCH][$];
  logic [NCH-1:0] m_aq, m_bq;
  logic [NCH-1:0] e_pass [2];
  logic [NCH-1:0] e_fail [2];
  int e_pc [2][NCH];
  int e_fc [2][NCH];
  logic e_err [2];
  int e_ffc [2];

  function automatic int mn(int n); return (n == 0) ? MIN_A : MIN_B; endfunction
  function automatic int mx(int n); return (n == 0) ? MAX_A : MAX_B; endfunction
  function automatic int cmax(int n); return (n == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1); endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < NCH; c++) begin
        lq[n][c].delete();
        e_pc[n][c] = 0;
        e_fc[n][c] = 0;
      end
      e_pass[n] = '0;
      e_fail[n] = '0;
      e_err[n] = 1'b0;
      e_ffc[n] = 0;
    end
    m_aq = '0;
    m_bq = '0;
  endtask

  task automatic model_edge();
    int keep [$];
    int age;
    if (rst_n) begin
      for (int n = 0; n < 2; n++) begin
        for (int c = 0; c < NCH; c++) begin
          logic ra, rb, p, f;
          ra = a_in[c] & ~m_aq[c];
          rb = b_in[c] & ~m_bq[c];
          p = 1'b0;
          f = 1'b0;
          keep.delete();
          foreach (lq[n][c][k]) begin
            age = cyc - lq[n][c][k];
            if (rb && age >= mn(n) && age <= mx(n)) p = 1'b1;
            else if (age >= mx(n)) f = 1'b1;
            else keep.push_back(lq[n][c][k]);
          end
          if (ra && en_in) keep.push_back(cyc);
          lq[n][c] = keep;
          e_pass[n][c] = p;
          e_fail[n][c] = f;
          if (clr_in) begin
            e_pc[n][c] = p ? 1 : 0;
            e_fc[n][c] = f ? 1 : 0;
          end else begin
            if (p && e_pc[n][c] < cmax(n)) e_pc[n][c]++;
            if (f && e_fc[n][c] < cmax(n)) e_fc[n][c]++;
          end
        end
        if (clr_in || (!e_err[n] && e_fail[n] != 0)) begin
          e_err[n] = (e_fail[n] != 0);
          e_ffc[n] = 0;
          for (int c = NCH - 1; c >= 0; c--) if (e_fail[n][c]) e_ffc[n] = c;
        end
      end
      m_aq = a_in;
      m_bq = b_in;
    end
    cyc++;
  endtask

  task automatic chk(string nm, int n, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d got=%0d exp=%0d", nm, n, cyc, got, exp);
    end
  endtask

  function automatic int got_pc(int n, int c);
    return (n == 0) ? int'(pcnt_a[c*CW_A +: CW_A]) : int'(pcnt_b[c*CW_B +: CW_B]);
  endfunction
  function automatic int got_fc(int n, int c);
    return (n == 0) ? int'(fcnt_a[c*CW_A +: CW_A]) : int'(fcnt_b[c*CW_B +: CW_B]);
  endfunction

  task automatic compare_all();
    for (int n = 0; n < 2; n++) begin
      chk("pass_o", n, (n == 0) ? pass_a : pass_b, e_pass[n]);
      chk("fail_o", n, (n == 0) ? fail_a : fail_b, e_fail[n]);
      chk("err_o", n, (n == 0) ? err_a : err_b, e_err[n]);
      chk("first_fail_ch_o", n, (n == 0) ? ffc_a : ffc_b, e_ffc[n]);
      for (int c = 0; c < NCH; c++) begin
        chk("pass_cnt", n, got_pc(n, c), e_pc[n][c]);
        chk("fail_cnt", n, got_fc(n, c), e_fc[n][c]);
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(logic [NCH-1:0] a, logic [NCH-1:0] b, logic en, logic clr);
    a_in = a;
    b_in = b;
    en_in = en;
    clr_in = clr;
  endtask

  task automatic idle(int n);
    set_in('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [NCH-1:0] a, b;
    logic en, clr;
    logic [NCH-1:0] xp, xf;
    logic xerr;
    logic [1:0] xffc;
  } vec_t;
  vec_t tbl [13];

  initial begin
    // Rows for the exact-delay instance: pass/fail on ch0/ch1, simultaneous fail ch0+ch2, clear, en_i blocking.
    tbl[0]  = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[1]  = '{4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[2]  = '{4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[3]  = '{4'h3, 4'h1, 1'b1, 1'b0, 4'h1, 4'h2, 1'b1, 2'd1};
    tbl[4]  = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1};
    tbl[5]  = '{4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[6]  = '{4'h5, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[7]  = '{4'h5, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[8]  = '{4'h5, 4'h0, 1'b1, 1'b0, 4'h0, 4'h5, 1'b1, 2'd0};
    tbl[9]  = '{4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[10] = '{4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[11] = '{4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    for (int r = 0; r < 13; r++) begin
      set_in(tbl[r].a, tbl[r].b, tbl[r].en, tbl[r].clr);
      tick();
      chk("tbl_pass", r, pass_a, tbl[r].xp);
      chk("tbl_fail", r, fail_a, tbl[r].xf);
      chk("tbl_err", r, err_a, tbl[r].xerr);
      chk("tbl_ffc", r, ffc_a, tbl[r].xffc);
    end
    chk("tbl_pcnt_ch0", 0, got_pc(0, 0), 0);
    idle(6);

    // Overlap on the exact-delay instance: b-rise passes the older attempt while a new one launches.
    set_in('0, '0, 1'b1, 1'b1); tick();
    set_in(4'h1, '0, 1'b1, 1'b0); tick();
    set_in(4'h0, '0, 1'b1, 1'b0); tick();
    set_in(4'h1, 4'h1, 1'b1, 1'b0); tick();
    chk("ovl_pass", 0, pass_a[0], 1'b1);
    chk("ovl_nofail", 0, fail_a[0], 1'b0);
    set_in(4'h0, 4'h0, 1'b1, 1'b0); tick();
    chk("ovl_gap", 0, pass_a[0] | fail_a[0], 1'b0);
    tick();
    chk("ovl_fail", 0, fail_a[0], 1'b1);
    chk("ovl_err", 0, err_a, 1'b1);
    idle(6);

    // Windowed instance: two attempts in flight both discharged by one b-rise.
    set_in('0, '0, 1'b1, 1'b1); tick();
    set_in(4'h1, '0, 1'b1, 1'b0); tick();
    set_in(4'h0, '0, 1'b1, 1'b0); tick();
    set_in(4'h1, '0, 1'b1, 1'b0); tick();
    set_in(4'h0, '0, 1'b1, 1'b0); tick();
    set_in(4'h0, 4'h1, 1'b1, 1'b0); tick();
    chk("win_pass", 1, pass_b[0], 1'b1);
    chk("win_pcnt", 1, got_pc(1, 0), 1);
    set_in('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("win_nofail", 1, fail_b[0] | pass_b[0], 1'b0);
    end
    chk("win_err", 1, err_b, 1'b0);

    // Reset while an attempt is pending: dropped without a fail.
    set_in(4'h1, '0, 1'b1, 1'b0); tick();
    set_in('0, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_err", 0, err_a, 1'b0);
    chk("rst_pcnt", 1, got_pc(1, 0), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_nofail", 0, fail_a | fail_b, 0);
    end

    // Saturation of a narrow counter: ch3 passes every second edge.
    set_in('0, '0, 1'b1, 1'b1); tick();
    for (int i = 0; i < 40; i++) begin
      set_in((i % 2 == 0) ? 4'h8 : 4'h0, (i % 2 == 0) ? 4'h8 : 4'h0, 1'b1, 1'b0);
      tick();
    end
    chk("sat_pcnt", 0, got_pc(0, 3), 15);
    idle(6);

    // Randomized traffic with rare clears and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        set_in('0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      set_in(4'($urandom), 4'($urandom), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
